// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the execute-stage ALU.
//   WIDTH    : datapath width (32 only)
//   RD_W     : destination register tag width
//   op_t     : 3-bit operation encoding (110/111 are illegal)
//   fwd_sel_t: operand forwarding source select
//   state_t  : execute-stage sequencer state
// Optional feature macro: ALU_MUL_EN (consumed by alu_ex_stage / mul_seq).
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int RD_W  = 5;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLT  = 3'b100,
    OP_MUL  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    FWD_SRC = 2'b00,
    FWD_OUT = 2'b01,
    FWD_WB  = 2'b10,
    FWD_RSV = 2'b11
  } fwd_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    MUL_RUN = 1'b1
  } state_t;

endpackage

// File: rtl/alu_ex_stage_mul_seq.sv
// -----------------------------------------------------------------------------
// mul_seq
// Unsigned 32x32 shift-add multiply sequencer. Only built with ALU_MUL_EN.
// It owns no adder: the top-level 32-bit adder is borrowed through
// add_a/add_b (requests) and add_sum/add_cout (results) while run is high.
//   clk, rst_n          : clock, async active-low reset (counter only)
//   start               : latch operands (acceptance edge of a MUL)
//   run                 : one iteration per cycle while high
//   mcand_in, mplier_in : multiplicand / multiplier
//   add_a, add_b        : operands driven onto the shared adder
//   add_sum, add_cout   : shared adder result and carry-out
//   done                : high in the cycle of the final iteration
//   prod_lo             : low 32 product bits (valid with done)
//   prod_hi_nz          : any upper product bit set (valid with done)
// -----------------------------------------------------------------------------
module mul_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             run,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic             prod_hi_nz
);

  logic [5:0]         cnt_p1;
  logic [2*WIDTH-1:0] prod_p1;
  logic [WIDTH-1:0]   mcand_p1;
  logic [2*WIDTH-1:0] prod_nxt;

  // Upper half accumulates the multiplicand when the current multiplier
  // bit (LSB of the product register) is set; the whole register then
  // shifts right with the carry-out entering at the top.
  assign add_a    = prod_p1[2*WIDTH-1:WIDTH];
  assign add_b    = prod_p1[0] ? mcand_p1 : '0;
  assign prod_nxt = {add_cout, add_sum, prod_p1[WIDTH-1:1]};

  // The final iteration's product is handed out combinationally so the
  // output register can load it on the same edge.
  assign done       = run && (cnt_p1 == 6'(WIDTH - 1));
  assign prod_lo    = prod_nxt[WIDTH-1:0];
  assign prod_hi_nz = |prod_nxt[2*WIDTH-1:WIDTH];

  // ---- stage p1: iteration counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1 <= '0;
    end else if (start) begin
      cnt_p1 <= '0;
    end else if (run) begin
      cnt_p1 <= cnt_p1 + 6'd1;
    end
  end

  // ---- stage p1: product / multiplicand registers ----
  always_ff @(posedge clk) begin
    if (start) begin
      prod_p1  <= {{WIDTH{1'b0}}, mplier_in};
      mcand_p1 <= mcand_in;
    end else if (run) begin
      prod_p1  <= prod_nxt;
    end
  end

endmodule

// File: rtl/alu_ex_stage.sv
// -----------------------------------------------------------------------------
// alu_ex_stage
// Execute-stage ALU: forwarding muxes, single-cycle ADD/SUB/AND/OR/SLT on a
// shared 32-bit adder, optional multi-cycle MUL, single-entry output register
// with valid/ready backpressure.
// Macro ALU_MUL_EN: when defined, MUL (op 101) runs on the mul_seq sequencer
// and the MUL_RUN state exists; when undefined, op 101 is illegal, busy = 0
// and the FSM stays in IDLE.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   in_valid / in_ready    : upstream handshake
//   op                     : operation (see alu_pkg::op_t)
//   src_a, src_b           : register-file operands
//   fwd_a_sel, fwd_b_sel   : 00 src, 01 out_result, 10 wb_data, 11 as 00
//   wb_data                : writeback-stage forwarded value
//   rd                     : destination tag
//   out_valid / out_ready  : downstream handshake
//   out_result, out_rd     : result and its tag
//   out_ovf, out_illegal   : overflow / illegal-op flags
//   busy                   : multiply in progress
// -----------------------------------------------------------------------------
module alu_ex_stage
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       fwd_a_sel,
  input  logic [1:0]       fwd_b_sel,
  input  logic [WIDTH-1:0] wb_data,
  input  logic [RD_W-1:0]  rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             busy
);

  // Signed overflow of a + b = s: operands agree in sign, sum does not.
  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [WIDTH-1:0] fwd_mux(input logic [1:0]       sel,
                                               input logic [WIDTH-1:0] src,
                                               input logic [WIDTH-1:0] held,
                                               input logic [WIDTH-1:0] wb);
    case (fwd_sel_t'(sel))
      FWD_OUT: return held;
      FWD_WB:  return wb;
      default: return src;
    endcase
  endfunction

  state_t           state_q, state_nxt;
  op_t              opc;
  logic             accept, is_mul, is_sub, load;
  logic [WIDTH-1:0] opa, opb;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin;
  logic [WIDTH-1:0] alu_res, ld_res;
  logic             alu_ovf, alu_ill, ld_ovf, ld_ill;
  logic [RD_W-1:0]  ld_rd;

  logic             vld_p1, ovf_p1, ill_p1;
  logic [WIDTH-1:0] res_p1;
  logic [RD_W-1:0]  rd_p1;

  assign opc      = op_t'(op);
  // Forwarding from out_result sees the register as it stands, stalled or not.
  assign opa      = fwd_mux(fwd_a_sel, src_a, res_p1, wb_data);
  assign opb      = fwd_mux(fwd_b_sel, src_b, res_p1, wb_data);
  assign in_ready = (state_q == IDLE) && (!vld_p1 || out_ready);
  assign accept   = in_valid && in_ready;
  // SLT is decided from A - B, so it shares the subtract path.
  assign is_sub   = (opc == OP_SUB) || (opc == OP_SLT);

`ifdef ALU_MUL_EN
  logic             add_cout, mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_add_a, mul_add_b, mul_lo;
  logic [RD_W-1:0]  mul_rd_p1;

  assign is_mul = (opc == OP_MUL);
  assign busy   = (state_q == MUL_RUN);
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  mul_seq u_mul_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (accept && is_mul),
    .run        (state_q == MUL_RUN),
    .mcand_in   (opa),
    .mplier_in  (opb),
    .add_a      (mul_add_a),
    .add_b      (mul_add_b),
    .add_sum    (add_sum),
    .add_cout   (add_cout),
    .done       (mul_done),
    .prod_lo    (mul_lo),
    .prod_hi_nz (mul_hi_nz)
  );

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      mul_rd_p1 <= rd;
    end
  end
`else
  assign is_mul  = 1'b0;
  assign busy    = 1'b0;
  assign add_sum = add_a + add_b + {{(WIDTH-1){1'b0}}, add_cin};
`endif

  // Shared adder operand select: ALU in IDLE, sequencer during MUL_RUN.
  always_comb begin
    add_a   = opa;
    add_b   = is_sub ? ~opb : opb;
    add_cin = is_sub;
`ifdef ALU_MUL_EN
    if (state_q == MUL_RUN) begin
      add_a   = mul_add_a;
      add_b   = mul_add_b;
      add_cin = 1'b0;
    end
`endif
  end

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (opc)
      OP_ADD, OP_SUB: begin
        alu_res = add_sum;
        alu_ovf = add_ovf(add_a, add_b, add_sum);
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, add_sum[WIDTH-1] ^ add_ovf(add_a, add_b, add_sum)};
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    load      = 1'b0;
    ld_res    = alu_res;
    ld_ovf    = alu_ovf;
    ld_ill    = alu_ill;
    ld_rd     = rd;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_nxt = MUL_RUN;
          end else begin
            load = 1'b1;
          end
        end
      end
`ifdef ALU_MUL_EN
      MUL_RUN: begin
        if (mul_done) begin
          load      = 1'b1;
          state_nxt = IDLE;
          ld_res    = mul_lo;
          ld_ovf    = mul_hi_nz;
          ld_ill    = 1'b0;
          ld_rd     = mul_rd_p1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      rd_p1  <= '0;
      ovf_p1 <= 1'b0;
      ill_p1 <= 1'b0;
    end else if (load) begin
      vld_p1 <= 1'b1;
      res_p1 <= ld_res;
      rd_p1  <= ld_rd;
      ovf_p1 <= ld_ovf;
      ill_p1 <= ld_ill;
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid   = vld_p1;
  assign out_result  = res_p1;
  assign out_rd      = rd_p1;
  assign out_ovf     = ovf_p1;
  assign out_illegal = ill_p1;

endmodule
